// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder controller: feeds an external 1-bit full-adder cell one bit pair per
// clock (LSB first), recirculates its carry and collects the sum bits into a result register.
module serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic         ck,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         fa_a,
    output logic         fa_b,
    output logic         fa_c,
    input  logic         fa_s,
    input  logic         fa_co,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [N-1:0]     a_sh_q;
    logic [N-1:0]     b_sh_q;
    logic [N-1:0]     sum_sh_q;
    logic [N-1:0]     sum_sh_d;
    logic [N-1:0]     sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    // New sum bit enters at the MSB so that after N shifts bit 0 holds the first (LSB) sum.
    generate
        if (N == 1) begin : g_sum_one
            assign sum_sh_d = fa_s;
        end else begin : g_sum_many
            assign sum_sh_d = {fa_s, sum_sh_q[N-1:1]};
        end
    endgenerate

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        carry_q  <= cin;
                        cnt_q    <= '0;
                        sum_sh_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    sum_sh_q <= sum_sh_d;
                    carry_q  <= fa_co;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    // Last bit: capture the result here so sum/cout are valid while done is high.
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= sum_sh_d;
                        cout_q  <= fa_co;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fa_a = a_sh_q[0];
    assign fa_b = b_sh_q[0];
    assign fa_c = carry_q;
    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: N=8 and N=1 instances, each wired to a behavioural full-adder
// cell; results are compared against plain a+b+cin arithmetic.
module tb_serial_adder_ctrl;

    logic ck = 1'b0;
    logic rst_n;
    always #5 ck = ~ck;

    int errors = 0;
    int checks = 0;

    // N = 8 instance
    logic       st8, c8;
    logic [7:0] a8, b8;
    logic       fa_a8, fa_b8, fa_c8, fa_s8, fa_co8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    assign fa_s8  = fa_a8 ^ fa_b8 ^ fa_c8;
    assign fa_co8 = (fa_a8 & fa_b8) | (fa_a8 & fa_c8) | (fa_b8 & fa_c8);

    serial_adder_ctrl #(.N(8)) dut8 (
        .ck(ck), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .cin(c8),
        .fa_a(fa_a8), .fa_b(fa_b8), .fa_c(fa_c8), .fa_s(fa_s8), .fa_co(fa_co8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    // N = 1 instance
    logic       st1, a1, b1, c1;
    logic       fa_a1, fa_b1, fa_c1, fa_s1, fa_co1;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    assign fa_s1  = fa_a1 ^ fa_b1 ^ fa_c1;
    assign fa_co1 = (fa_a1 & fa_b1) | (fa_a1 & fa_c1) | (fa_b1 & fa_c1);

    serial_adder_ctrl #(.N(1)) dut1 (
        .ck(ck), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .cin(c1),
        .fa_a(fa_a1), .fa_b(fa_b1), .fa_c(fa_c1), .fa_s(fa_s1), .fa_co(fa_co1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    // Latency is counted with the accepted-start edge as edge 1, so done should be seen at N+1.
    task automatic add8(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                        input bit poke_busy, output int lat, output logic [7:0] s,
                        output logic co, output int extra, output bit hold_ok,
                        output int busy_bad);
        @(negedge ck);
        a8 = ta; b8 = tbv; c8 = tc; st8 = 1'b1;
        @(posedge ck); #1;
        st8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        lat = 1; busy_bad = 0;
        while (done8 !== 1'b1 && lat < 30) begin
            if (busy8 !== 1'b1) busy_bad++;
            if (poke_busy) st8 = (lat == 3);
            @(posedge ck); #1;
            lat++;
        end
        st8 = 1'b0;
        if (busy8 !== 1'b0) busy_bad++;
        s = sum8; co = cout8; extra = 0; hold_ok = 1'b1;
        repeat (4) begin
            @(posedge ck); #1;
            if (done8 === 1'b1) extra++;
            if (sum8 !== s || cout8 !== co) hold_ok = 1'b0;
        end
    endtask

    task automatic add1(input logic ta, input logic tbv, input logic tc,
                        output int lat, output logic s, output logic co);
        @(negedge ck);
        a1 = ta; b1 = tbv; c1 = tc; st1 = 1'b1;
        @(posedge ck); #1;
        st1 = 1'b0;
        lat = 1;
        while (done1 !== 1'b1 && lat < 20) begin
            @(posedge ck); #1;
            lat++;
        end
        s = sum1[0]; co = cout1;
        repeat (2) @(posedge ck);
    endtask

    task automatic test_reset();
        int lat, extra, bb; logic [7:0] s; logic co; bit hold;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy8, done8, sum8, cout8, fa_a8, fa_b8, fa_c8} !== 13'd0) begin
            errors++;
            $display("FAIL reset_initial: got %b required 0",
                     {busy8, done8, sum8, cout8, fa_a8, fa_b8, fa_c8});
        end
        @(negedge ck); rst_n = 1'b1;
        add8(8'h5A, 8'h3C, 1'b1, 1'b0, lat, s, co, extra, hold, bb);
        @(negedge ck);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; st8 = 1'b1;
        @(posedge ck); #1; st8 = 1'b0;
        @(posedge ck); #1;
        checks++;
        if ({busy8, fa_a8, fa_b8, fa_c8, sum8} !== {4'b1111, 8'h97}) begin
            errors++;
            $display("FAIL reset_prearm: got %b required %b",
                     {busy8, fa_a8, fa_b8, fa_c8, sum8}, {4'b1111, 8'h97});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, sum8, cout8, fa_a8, fa_b8, fa_c8} !== 13'd0) begin
            errors++;
            $display("FAIL reset_async: got %b required 0",
                     {busy8, done8, sum8, cout8, fa_a8, fa_b8, fa_c8});
        end
        @(negedge ck); rst_n = 1'b1;
    endtask

    task automatic test_zero();
        int lat, extra, bb; logic [7:0] s; logic co; bit hold;
        add8(8'h00, 8'h00, 1'b0, 1'b0, lat, s, co, extra, hold, bb);
        checks++;
        if (lat != 9 || s !== 8'h00 || co !== 1'b0 || extra != 0) begin
            errors++;
            $display("FAIL zero_add: lat=%0d sum=%h cout=%b extra=%0d required lat=9 sum=00 cout=0 extra=0",
                     lat, s, co, extra);
        end
    endtask

    task automatic test_carry();
        int lat, extra, bb; logic [7:0] s; logic co; bit hold;
        add8(8'hFF, 8'h01, 1'b0, 1'b0, lat, s, co, extra, hold, bb);
        checks++;
        if (lat != 9 || s !== 8'h00 || co !== 1'b1) begin
            errors++;
            $display("FAIL carry_ff_01: lat=%0d sum=%h cout=%b required lat=9 sum=00 cout=1", lat, s, co);
        end
        add8(8'hFF, 8'hFF, 1'b1, 1'b0, lat, s, co, extra, hold, bb);
        checks++;
        if (lat != 9 || s !== 8'hFF || co !== 1'b1) begin
            errors++;
            $display("FAIL carry_ff_ff_1: lat=%0d sum=%h cout=%b required lat=9 sum=ff cout=1", lat, s, co);
        end
    endtask

    task automatic test_busy_ignored();
        int lat, extra, bb; logic [7:0] s; logic co; bit hold;
        add8(8'h5A, 8'h3C, 1'b1, 1'b1, lat, s, co, extra, hold, bb);
        checks++;
        if (lat != 9 || s !== 8'h97 || co !== 1'b0) begin
            errors++;
            $display("FAIL busy_result: lat=%0d sum=%h cout=%b required lat=9 sum=97 cout=0", lat, s, co);
        end
        checks++;
        if (extra != 0 || !hold || bb != 0) begin
            errors++;
            $display("FAIL busy_handshake: extra_done=%0d hold=%0d busy_bad=%0d required 0 1 0",
                     extra, hold, bb);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, extra, bb, seen; logic [7:0] s; logic co; bit hold;
        @(negedge ck);
        a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; st8 = 1'b1;
        @(posedge ck); #1; st8 = 1'b0;
        repeat (3) @(posedge ck);
        #1 rst_n = 1'b0;
        seen = 0;
        @(negedge ck); rst_n = 1'b1;
        repeat (12) begin
            @(posedge ck); #1;
            if (done8 === 1'b1 || busy8 === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: busy/done cycles=%0d required 0", seen);
        end
        add8(8'h12, 8'h34, 1'b0, 1'b0, lat, s, co, extra, hold, bb);
        checks++;
        if (lat != 9 || s !== 8'h46 || co !== 1'b0) begin
            errors++;
            $display("FAIL after_abort: lat=%0d sum=%h cout=%b required lat=9 sum=46 cout=0", lat, s, co);
        end
    endtask

    task automatic test_back_to_back();
        int dones, lat; int pos[$];
        @(negedge ck);
        a8 = 8'h81; b8 = 8'h7F; c8 = 1'b0; st8 = 1'b1;
        @(posedge ck); #1;
        lat = 1; dones = 0;
        // Start stays high: each new addition is accepted as soon as the FSM is back in IDLE.
        while (lat < 30) begin
            @(posedge ck); #1;
            lat++;
            if (done8 === 1'b1) begin
                dones++;
                pos.push_back(lat);
                checks++;
                if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_result: sum=%h cout=%b required sum=00 cout=1", sum8, cout8);
                end
            end
        end
        st8 = 1'b0;
        checks++;
        if (dones != 3 || pos[0] != 9 || pos[1] != 19 || pos[2] != 29) begin
            errors++;
            $display("FAIL b2b_spacing: dones=%0d first=%0d required 3 dones at 9,19,29",
                     dones, (pos.size() > 0) ? pos[0] : -1);
        end
        repeat (12) @(posedge ck);
    endtask

    task automatic test_n1_exhaustive();
        int lat; logic s, co; logic [1:0] ref_v;
        for (int i = 0; i < 8; i++) begin
            ref_v = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
            add1(i[2], i[1], i[0], lat, s, co);
            checks++;
            if (lat != 2 || {co, s} !== ref_v) begin
                errors++;
                $display("FAIL n1_combo%0d: lat=%0d cout,sum=%b%b required lat=2 %b",
                         i, lat, co, s, ref_v);
            end
        end
    endtask

    task automatic test_random();
        int lat, extra, bb; logic [7:0] s, ta, tbv; logic co, tc; bit hold;
        logic [8:0] ref_v;
        for (int k = 0; k < 1000; k++) begin
            ta = 8'($urandom); tbv = 8'($urandom); tc = 1'($urandom);
            ref_v = 9'(ta) + 9'(tbv) + 9'(tc);
            add8(ta, tbv, tc, 1'($urandom_range(0, 1)), lat, s, co, extra, hold, bb);
            checks++;
            if (lat != 9 || {co, s} !== ref_v || extra != 0 || !hold || bb != 0) begin
                errors++;
                $display("FAIL random%0d: %h+%h+%b got lat=%0d %h extra=%0d required lat=9 %h",
                         k, ta, tbv, tc, lat, {co, s}, extra, ref_v);
            end
        end
    endtask

    initial begin
        st8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        st1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        test_reset();
        test_zero();
        test_carry();
        test_busy_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_n1_exhaustive();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
